// File: rtl/reg_file_param.sv
// Parameterised register file: two registered read ports with write bypass,
// one byte-enabled write port, and a post-reset clear sequence that zeroes
// every register before the file reports ready.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    // One extra bit so the index can never wrap before the clear finishes.
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CLR_STEP = (ADDR_W + 1)'(1);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     clr_idx_q, clr_idx_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0]   rd_data2_q, rd_data2_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [DATA_W-1:0]   wr_merged;
    logic                wr_fire;

    // Register 0 is hardwired to zero when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Value a read port returns in READY: zero register, bypassed write, or stored word.
    function automatic logic [DATA_W-1:0] read_value(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic [DATA_W-1:0] merged,
        input logic              hit
    );
        if (is_zero_reg(addr)) begin
            return '0;
        end
        return hit ? merged : stored;
    endfunction

    // Merge enabled bytes of wr_data over the current word at wr_addr.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        wr_merged = mem_q[wr_addr];
        for (int k = 0; k < BE_W; k++) begin
            if (wr_be[k]) begin
                wr_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
        wr_fire = (state_q == READY) && wr_en && (|wr_be) && !is_zero_reg(wr_addr);
    end

    // Next-state logic for the CLEAR/READY controller and the read ports.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        busy_d     = busy_q;
        rd_data1_d = '0;
        rd_data2_d = '0;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + CLR_STEP;
            if (clr_idx_q == CLR_LAST) begin
                state_d = READY;
                busy_d  = 1'b0;
            end else begin
                busy_d  = 1'b1;
            end
        end else begin
            busy_d     = 1'b0;
            rd_data1_d = read_value(rd_addr1, mem_q[rd_addr1], wr_merged,
                                    wr_en && (rd_addr1 == wr_addr));
            rd_data2_d = read_value(rd_addr2, mem_q[rd_addr2], wr_merged,
                                    wr_en && (rd_addr2 == wr_addr));
        end
    end

    // Controller state and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            busy_q     <= 1'b1;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            busy_q     <= busy_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
        end
    end

    // Storage array: zeroed by the clear sequence, then written through the write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; its contents come from the clear sequence, which keeps it mappable to RAM.
        if (rst_n) begin
            if (state_q == CLEAR) begin
                mem_q[clr_idx_q[ADDR_W-1:0]] <= '0;
            end else if (wr_fire) begin
                mem_q[wr_addr] <= wr_merged;
            end
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (default parameters) against a
// behavioural model of the register file kept as a plain array.
module tb_reg_file_param;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [31:0] m_mem [32];
    int          clear_pos = 0;
    bit          clearing  = 1;
    logic        exp_busy  = 1'b1;
    logic [31:0] exp_rd1   = '0;
    logic [31:0] exp_rd2   = '0;

    reg_file_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return 32'h0;
        if (wr_en && int'(wr_addr) == a) return merge(m_mem[a], wr_data, wr_be);
        return m_mem[a];
    endfunction

    // Apply one rising edge to the model using the inputs held before it.
    task automatic model_edge();
        if (!rst_n) begin
            clear_pos = 0;
            clearing  = 1;
            exp_busy  = 1'b1;
            exp_rd1   = '0;
            exp_rd2   = '0;
        end else if (clearing) begin
            m_mem[clear_pos] = '0;
            clear_pos++;
            if (clear_pos == 32) begin
                clearing = 0;
                exp_busy = 1'b0;
            end
            exp_rd1 = '0;
            exp_rd2 = '0;
        end else begin
            exp_rd1 = model_read(int'(rd_addr1));
            exp_rd2 = model_read(int'(rd_addr2));
            if (wr_en && wr_addr != 5'd0)
                m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        wr_en = en; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b1 || rd_data1 !== 32'h0 || rd_data2 !== 32'h0)
            $display("FAIL reset_state: busy=%b rd1=%h rd2=%h want busy=1 rd=0", busy, rd_data1, rd_data2);
        else n_pass++;
        rst_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt !== 32) $display("FAIL reset_busy_len: got %0d cycles want 32", cnt);
        else n_pass++;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            tick();
            n_checks++;
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0)
                $display("FAIL reset_read_%0d: rd1=%h rd2=%h want 0", a, rd_data1, rd_data2);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        set_wr(1'b1, 5'd9, 32'hDEADBEEF, 4'hF);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        rd_addr1 = 5'd9;
        tick();
        n_checks++;
        if (rd_data1 !== 32'hDEADBEEF) $display("FAIL write_read: got %h want deadbeef", rd_data1);
        else n_pass++;
    endtask

    task automatic test_bypass();
        set_wr(1'b1, 5'd8, 32'h12345678, 4'hF);
        rd_addr1 = 5'd8;
        rd_addr2 = 5'd8;
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        n_checks++;
        if (rd_data1 !== 32'h12345678 || rd_data2 !== 32'h12345678)
            $display("FAIL bypass: rd1=%h rd2=%h want 12345678", rd_data1, rd_data2);
        else n_pass++;
    endtask

    task automatic test_byte_en();
        set_wr(1'b1, 5'd2, 32'hAABBCCDD, 4'hF);
        tick();
        set_wr(1'b1, 5'd2, 32'h11223344, 4'b0101);
        rd_addr1 = 5'd2;
        tick();
        n_checks++;
        if (rd_data1 !== 32'hAA22CC44) $display("FAIL byte_en_bypass: got %h want aa22cc44", rd_data1);
        else n_pass++;
        set_wr(1'b1, 5'd2, 32'h99999999, 4'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        n_checks++;
        if (rd_data1 !== 32'hAA22CC44) $display("FAIL byte_en_zero_be_bypass: got %h want aa22cc44", rd_data1);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_data1 !== 32'hAA22CC44) $display("FAIL byte_en_stored: got %h want aa22cc44", rd_data1);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        n_checks++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0)
            $display("FAIL zero_reg_bypass: rd1=%h rd2=%h want 0", rd_data1, rd_data2);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0)
            $display("FAIL zero_reg_after: rd1=%h rd2=%h want 0", rd_data1, rd_data2);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            tick();
            n_checks++;
            if (rd_data1 !== exp_rd1 || rd_data2 !== exp_rd2 || busy !== exp_busy)
                $display("FAIL random_%0d: rd1=%h rd2=%h busy=%b want %h %h %b",
                         i, rd_data1, rd_data2, busy, exp_rd1, exp_rd2, exp_busy);
            else n_pass++;
        end
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    task automatic test_mid_clear();
        int cnt;
        rd_addr1 = 5'd9;
        rd_addr2 = 5'd5;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_wr(1'b1, 5'd5, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 2) begin
                n_checks++;
                if (rd_data1 !== 32'h0 || busy !== 1'b1)
                    $display("FAIL clear_read_zero: rd1=%h busy=%b want 0 1", rd_data1, busy);
                else n_pass++;
            end
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1 || rd_data1 !== 32'h0)
            $display("FAIL mid_clear_reset: busy=%b rd1=%h want 1 0", busy, rd_data1);
        else n_pass++;
        rst_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt !== 32) $display("FAIL mid_clear_busy_len: got %0d cycles want 32", cnt);
        else n_pass++;
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        rd_addr1 = 5'd5;
        tick();
        n_checks++;
        if (rd_data1 !== 32'h0 || rd_data1 !== exp_rd1)
            $display("FAIL mid_clear_r5: got %h want 0", rd_data1);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        for (int a = 0; a < 32; a++) m_mem[a] = 'x;
        test_reset();
        test_write_read();
        test_bypass();
        test_byte_en();
        test_zero_reg();
        test_random();
        test_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
